// File: rtl/flex_stp_rx_if.sv
// Serial-line and parallel-word handshake bundle for the flex_stp_rx framed receiver.
// master = the side driving the line and consuming words; slave = the receiver.
interface flex_stp_rx_if #(
   parameter int NUM_BITS = 8
);
   logic                shift_enable;
   logic                serial_in;
   logic                out_ready;
   logic                clear_errors;
   logic [NUM_BITS-1:0] parallel_out;
   logic                out_valid;
   logic                busy;
   logic                framing_error;
   logic                overrun_error;

   modport master (
      output shift_enable, serial_in, out_ready, clear_errors,
      input  parallel_out, out_valid, busy, framing_error, overrun_error
   );

   modport slave (
      input  shift_enable, serial_in, out_ready, clear_errors,
      output parallel_out, out_valid, busy, framing_error, overrun_error
   );
endinterface

// File: rtl/flex_stp_rx.sv
// Framed serial-to-parallel receiver: start bit, NUM_BITS data bits, stop bit, then a
// one-entry valid/ready holding register with sticky framing/overrun flags.
module flex_stp_rx #(
   parameter int NUM_BITS  = 8,
   parameter bit SHIFT_MSB = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   flex_stp_rx_if.slave  bus
);
   localparam int CW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_STOP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [NUM_BITS-1:0] sr_q, sr_d;
   logic [NUM_BITS-1:0] pout_q, pout_d;
   logic                ovalid_q, ovalid_d;
   logic                ferr_q, ferr_d;
   logic                oerr_q, oerr_d;

   logic accept;
   assign accept = ovalid_q && bus.out_ready;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sr_d     = sr_q;
      pout_d   = pout_q;
      ovalid_d = ovalid_q;
      ferr_d   = ferr_q;
      oerr_d   = oerr_q;

      if (accept) ovalid_d = 1'b0;
      // Clear first so a same-cycle error event below overrides it.
      if (bus.clear_errors) begin
         ferr_d = 1'b0;
         oerr_d = 1'b0;
      end

      if (bus.shift_enable) begin
         unique case (state_q)
            ST_IDLE: begin
               if (!bus.serial_in) begin
                  state_d = ST_DATA;
                  cnt_d   = '0;
               end
            end
            ST_DATA: begin
               if (SHIFT_MSB) sr_d = {sr_q[NUM_BITS-2:0], bus.serial_in};
               else           sr_d = {bus.serial_in, sr_q[NUM_BITS-1:1]};
               if (cnt_q == LAST_BIT) state_d = ST_STOP;
               else                   cnt_d   = cnt_q + 1'b1;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (!bus.serial_in) begin
                  ferr_d = 1'b1;
               end else if (!ovalid_q || bus.out_ready) begin
                  // Slot is free or being drained this cycle: a load here wins over the clear.
                  pout_d   = sr_q;
                  ovalid_d = 1'b1;
               end else begin
                  oerr_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         sr_q     <= '1;
         pout_q   <= '1;
         ovalid_q <= 1'b0;
         ferr_q   <= 1'b0;
         oerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sr_q     <= sr_d;
         pout_q   <= pout_d;
         ovalid_q <= ovalid_d;
         ferr_q   <= ferr_d;
         oerr_q   <= oerr_d;
      end
   end

   assign bus.parallel_out  = pout_q;
   assign bus.out_valid     = ovalid_q;
   assign bus.busy          = (state_q != ST_IDLE);
   assign bus.framing_error = ferr_q;
   assign bus.overrun_error = oerr_q;
endmodule

// File: tb/tb_flex_stp_rx.sv
// Directed bench for flex_stp_rx: an MSB-first and an LSB-first receiver share one line,
// checked by a frame table plus hand sequences for latency, reset, handshake and stalls.
module tb_flex_stp_rx;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   flex_stp_rx_if #(.NUM_BITS(8)) b1 ();
   flex_stp_rx_if #(.NUM_BITS(8)) b2 ();

   assign b2.shift_enable = b1.shift_enable;
   assign b2.serial_in    = b1.serial_in;
   assign b2.out_ready    = b1.out_ready;
   assign b2.clear_errors = b1.clear_errors;

   flex_stp_rx #(.NUM_BITS(8), .SHIFT_MSB(1'b1)) dut_msb (.clk(clk), .rst(rst), .bus(b1));
   flex_stp_rx #(.NUM_BITS(8), .SHIFT_MSB(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus(b2));

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One sample strobe followed by three idle clocks; returns 1 time unit after an edge.
   task automatic strobe(input logic b);
      b1.serial_in    = b;
      b1.shift_enable = 1'b1;
      tick();
      b1.shift_enable = 1'b0;
      repeat (3) tick();
   endtask

   task automatic send_data(input logic [7:0] d, input bit msb_first);
      strobe(1'b0);
      for (int i = 0; i < 8; i++) strobe(msb_first ? d[7-i] : d[i]);
   endtask

   typedef struct {
      bit         clr;
      logic       ready;
      logic [7:0] data;
      logic       stop;
      logic [7:0] exp_p1;
      logic [7:0] exp_p2;
      logic       exp_v;
      logic       exp_fe;
      logic       exp_oe;
   } vec_t;

   vec_t vecs [8];

   initial begin
      // Line sent MSB-first: the LSB-first receiver sees the bit-reversed word.
      vecs[0] = '{1'b0, 1'b1, 8'hA5, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 8'h3C, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 8'h11, 1'b1, 8'h11, 8'h88, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 8'h12, 1'b1, 8'h12, 8'h48, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 8'h34, 1'b1, 8'h12, 8'h48, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 1'b1, 8'h80, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 1'b1, 8'h01, 1'b1, 8'h01, 8'h80, 1'b0, 1'b0, 1'b0};

      rst = 1'b1;
      b1.shift_enable = 1'b0;
      b1.serial_in    = 1'b1;
      b1.out_ready    = 1'b0;
      b1.clear_errors = 1'b0;
      repeat (3) tick();
      chk("rst_busy",  b1.busy, 0);
      chk("rst_valid", b1.out_valid, 0);
      chk("rst_pout",  b1.parallel_out, 8'hFF);
      chk("rst_pout2", b2.parallel_out, 8'hFF);
      chk("rst_ferr",  b1.framing_error, 0);
      chk("rst_oerr",  b1.overrun_error, 0);
      rst = 1'b0;
      tick();

      // Asynchronous reset after start + 3 data bits.
      strobe(1'b0); strobe(1'b1); strobe(1'b0); strobe(1'b1);
      chk("mid_busy", b1.busy, 1);
      rst = 1'b1;
      #2;
      chk("mid_rst_busy",  b1.busy, 0);
      chk("mid_rst_valid", b1.out_valid, 0);
      chk("mid_rst_pout",  b1.parallel_out, 8'hFF);
      rst = 1'b0;
      tick();

      // A5 MSB-first with stop-strobe latency and accept timing.
      b1.out_ready = 1'b1;
      send_data(8'hA5, 1'b1);
      b1.serial_in    = 1'b1;
      b1.shift_enable = 1'b1;
      chk("lat_pre_valid", b1.out_valid, 0);
      tick();
      b1.shift_enable = 1'b0;
      chk("lat_valid", b1.out_valid, 1);
      chk("lat_pout",  b1.parallel_out, 8'hA5);
      tick();
      chk("acc_valid", b1.out_valid, 0);
      repeat (2) tick();

      // A5 sent LSB-first: the LSB-first receiver must rebuild A5.
      send_data(8'hA5, 1'b0);
      strobe(1'b1);
      chk("lsb_pout2", b2.parallel_out, 8'hA5);
      chk("lsb_valid", b2.out_valid, 0);

      for (int i = 0; i < 8; i++) begin
         b1.out_ready = vecs[i].ready;
         if (vecs[i].clr) begin
            b1.clear_errors = 1'b1;
            tick();
            b1.clear_errors = 1'b0;
         end
         send_data(vecs[i].data, 1'b1);
         strobe(vecs[i].stop);
         chk($sformatf("v%0d_pout", i),  b1.parallel_out,  vecs[i].exp_p1);
         chk($sformatf("v%0d_pout2", i), b2.parallel_out,  vecs[i].exp_p2);
         chk($sformatf("v%0d_valid", i), b1.out_valid,     vecs[i].exp_v);
         chk($sformatf("v%0d_ferr", i),  b1.framing_error, vecs[i].exp_fe);
         chk($sformatf("v%0d_oerr", i),  b1.overrun_error, vecs[i].exp_oe);
         chk($sformatf("v%0d_busy", i),  b1.busy,          0);
      end

      // Same-cycle accept of 12 and load of 56: no overrun, valid stays high.
      b1.out_ready = 1'b0;
      send_data(8'h12, 1'b1);
      strobe(1'b1);
      chk("hold_valid", b1.out_valid, 1);
      chk("hold_pout",  b1.parallel_out, 8'h12);
      send_data(8'h56, 1'b1);
      b1.serial_in    = 1'b1;
      b1.shift_enable = 1'b1;
      b1.out_ready    = 1'b1;
      tick();
      b1.shift_enable = 1'b0;
      b1.out_ready    = 1'b0;
      chk("same_valid", b1.out_valid, 1);
      chk("same_pout",  b1.parallel_out, 8'h56);
      chk("same_pout2", b2.parallel_out, 8'h6A);
      chk("same_oerr",  b1.overrun_error, 0);
      b1.out_ready = 1'b1;
      tick();
      b1.out_ready = 1'b0;
      chk("drain_valid", b1.out_valid, 0);
      chk("drain_pout",  b1.parallel_out, 8'h56);

      // 50-clock strobe stall mid-DATA on 6B.
      b1.out_ready = 1'b1;
      strobe(1'b0); strobe(1'b0); strobe(1'b1); strobe(1'b1);
      repeat (50) tick();
      chk("stall_busy", b1.busy, 1);
      chk("stall_valid", b1.out_valid, 0);
      strobe(1'b0); strobe(1'b1); strobe(1'b0); strobe(1'b1); strobe(1'b1);
      chk("stall_busy2", b1.busy, 1);
      strobe(1'b1);
      chk("stall_pout",  b1.parallel_out, 8'h6B);
      chk("stall_pout2", b2.parallel_out, 8'hD6);
      chk("stall_idle",  b1.busy, 0);
      chk("stall_ferr",  b1.framing_error, 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
